// File: rtl/ant_step_sequencer.sv
// Step-pacing controller for the ant logic: turns frame ticks and button edges into single-cycle
// step pulses. Optional auto-pause at C_STEP_LIMIT steps is enabled by defining STEP_SEQ_LIMIT_EN.
module ant_step_sequencer #(
    parameter int unsigned C_SPEED_W    = 3,
    parameter int unsigned C_STEP_CNT_W = 24,
    parameter int unsigned C_STEP_LIMIT = 11000
) (
    input  logic                    iclk,
    input  logic                    irstn,
    input  logic                    ivs,
    input  logic                    istart,
    input  logic                    isingle,
    input  logic [C_SPEED_W-1:0]    ispeed,
    input  logic                    ibusy,
    output logic                    ostep,
    output logic                    orunning,
    output logic [C_STEP_CNT_W-1:0] ostep_count,
    output logic                    osat
);

    // Wide enough to count up to 2^(2^C_SPEED_W - 1) - 1 frames at the slowest speed.
    localparam int unsigned FCNT_W = 2 ** C_SPEED_W;

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    state_e                  state_q, state_d;
    logic                    ivs_q, istart_q, isingle_q;
    logic [C_SPEED_W-1:0]    speed_q;
    logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
    logic                    pend_q, pend_d;
    logic                    go_q, go_d;
    logic                    ostep_q;
    logic [C_STEP_CNT_W-1:0] count_q, count_d;
    logic                    sat_q, sat_d;

    logic                    frame_tick, start_edge, single_edge, start_ok;
    logic                    due, want, pend_base;
    logic [FCNT_W-1:0]       period_m1;

    assign frame_tick  = ivs_q & ~ivs;
    assign start_edge  = istart & ~istart_q;
    assign single_edge = isingle & ~isingle_q;
    assign period_m1   = (FCNT_W'(1) << ispeed) - FCNT_W'(1);

`ifdef STEP_SEQ_LIMIT_EN
    logic lock_q, lock_d;
    logic limit_hit;

    assign limit_hit = ostep_q && (count_q != '1)
                       && ((count_q + C_STEP_CNT_W'(1)) == C_STEP_CNT_W'(C_STEP_LIMIT));
    assign start_ok  = start_edge & ~lock_q;
    assign lock_d    = lock_q | limit_hit;

    always_ff @(posedge iclk) begin
        if (!irstn) lock_q <= 1'b0;
        else        lock_q <= lock_d;
    end
`else
    assign start_ok = start_edge;

    // The limit value only matters when the auto-pause build option is enabled.
    if (C_STEP_LIMIT == 0) begin : g_no_limit
    end
`endif

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        due     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StRun;
                end else if (single_edge) begin
                    due     = 1'b1;
                    state_d = StPause;
                end
            end
            StRun: begin
                if (start_ok) begin
                    state_d = StPause;
                end else if (frame_tick && (ispeed == speed_q)) begin
                    if (fcnt_q == period_m1) begin
                        due    = 1'b1;
                        fcnt_d = '0;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
            end
            StPause: begin
                if (start_ok) begin
                    state_d = StRun;
                end else if (single_edge) begin
                    due = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef STEP_SEQ_LIMIT_EN
        if (limit_hit) state_d = StPause;
`endif

        if (ispeed != speed_q) fcnt_d = '0;

        // Any state change (into RUN, PAUSE or IDLE) restarts frame counting.
        pend_base = pend_q;
        if (state_d != state_q) begin
            fcnt_d = '0;
            if (state_d != StRun) pend_base = 1'b0;
        end

        // A step already in flight blocks issue so ostep can never be high twice in a row.
        want   = due | pend_base;
        go_d   = want & ~ibusy & ~go_q;
        pend_d = want & ~go_d;

        count_d = count_q;
        if (ostep_q && (count_q != '1)) count_d = count_q + C_STEP_CNT_W'(1);
        sat_d = sat_q | (count_d == '1);
    end

    always_ff @(posedge iclk) begin
        if (!irstn) begin
            ivs_q     <= ivs;
            istart_q  <= istart;
            isingle_q <= isingle;
            speed_q   <= ispeed;
            state_q   <= StIdle;
            fcnt_q    <= '0;
            pend_q    <= 1'b0;
            go_q      <= 1'b0;
            ostep_q   <= 1'b0;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else begin
            ivs_q     <= ivs;
            istart_q  <= istart;
            isingle_q <= isingle;
            speed_q   <= ispeed;
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            pend_q    <= pend_d;
            go_q      <= go_d;
            ostep_q   <= go_q;
            count_q   <= count_d;
            sat_q     <= sat_d;
        end
    end

    assign ostep       = ostep_q;
    assign orunning    = (state_q == StRun);
    assign ostep_count = count_q;
    assign osat        = sat_q;

endmodule

// File: tb/tb_ant_step_sequencer.sv
// Directed self-checking bench for ant_step_sequencer (default build and, when
// STEP_SEQ_LIMIT_EN is defined, the auto-pause limit).
module tb_ant_step_sequencer;

    logic        iclk = 1'b0;
    logic        irstn, rst_sat, rst_lim;
    logic        ivs, istart, isingle, ibusy;
    logic [2:0]  ispeed;
    logic        ostep, orunning, osat;
    logic [23:0] ostep_count;
    logic        s_step, s_run, s_sat;
    logic [2:0]  s_count;
    logic        l_step, l_run, l_sat;
    logic [23:0] l_count;

    int n_cmp = 0;
    int n_fail = 0;
    int pulses = 0;
    int consec = 0;
    logic ostep_prev = 1'b0;

    always #5 iclk = ~iclk;

    ant_step_sequencer u_dut (
        .iclk(iclk), .irstn(irstn), .ivs(ivs), .istart(istart), .isingle(isingle),
        .ispeed(ispeed), .ibusy(ibusy), .ostep(ostep), .orunning(orunning),
        .ostep_count(ostep_count), .osat(osat)
    );

    ant_step_sequencer #(.C_SPEED_W(3), .C_STEP_CNT_W(3)) u_sat (
        .iclk(iclk), .irstn(rst_sat), .ivs(ivs), .istart(istart), .isingle(isingle),
        .ispeed(ispeed), .ibusy(ibusy), .ostep(s_step), .orunning(s_run),
        .ostep_count(s_count), .osat(s_sat)
    );

    ant_step_sequencer #(.C_SPEED_W(3), .C_STEP_CNT_W(24), .C_STEP_LIMIT(4)) u_lim (
        .iclk(iclk), .irstn(rst_lim), .ivs(ivs), .istart(istart), .isingle(isingle),
        .ispeed(ispeed), .ibusy(ibusy), .ostep(l_step), .orunning(l_run),
        .ostep_count(l_count), .osat(l_sat)
    );

    always @(negedge iclk) begin
        if (ostep === 1'b1) pulses++;
        if (ostep === 1'b1 && ostep_prev === 1'b1) consec++;
        ostep_prev = ostep;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic frame();
        ivs = 1'b0;
        step(2);
        ivs = 1'b1;
        step(4);
    endtask

    task automatic start_edge();
        istart = 1'b1;
        step(1);
        istart = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        irstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ivs = ~ivs;
            step(1);
            n_cmp++;
            if ({ostep, orunning, osat, ostep_count} !== 27'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b/%b/%b/%0d want 0/0/0/0",
                         ostep, orunning, osat, ostep_count);
            end
        end
        ivs = 1'b1;
        step(1);
        irstn = 1'b1;
        step(2);
        for (int i = 0; i < 10; i++) frame();
        n_cmp++;
        if (ostep_count !== 24'd0 || pulses != 0) begin
            n_fail++;
            $display("FAIL idle_frames: count %0d pulses %0d want 0/0", ostep_count, pulses);
        end
    endtask

    task automatic test_run_speed0();
        istart = 1'b1;
        step(1);
        n_cmp++;
        if (orunning !== 1'b1) begin
            n_fail++;
            $display("FAIL run_enter: orunning %b want 1", orunning);
        end
        istart = 1'b0;
        step(1);
        for (int f = 0; f < 5; f++) begin
            ivs = 1'b0;
            step(1);
            n_cmp++;
            if (ostep !== 1'b0) begin
                n_fail++;
                $display("FAIL tick_lat_early f%0d: ostep %b want 0", f, ostep);
            end
            step(1);
            n_cmp++;
            if (ostep !== 1'b1) begin
                n_fail++;
                $display("FAIL tick_lat_pulse f%0d: ostep %b want 1", f, ostep);
            end
            ivs = 1'b1;
            step(1);
            n_cmp++;
            if (ostep !== 1'b0) begin
                n_fail++;
                $display("FAIL tick_lat_width f%0d: ostep %b want 0", f, ostep);
            end
            step(3);
        end
        n_cmp++;
        if (ostep_count !== 24'd5 || orunning !== 1'b1) begin
            n_fail++;
            $display("FAIL run5: count %0d run %b want 5/1", ostep_count, orunning);
        end
    endtask

    task automatic test_rate();
        int base;
        ispeed = 3'd2;
        step(2);
        base = pulses;
        for (int f = 1; f <= 12; f++) begin
            frame();
            n_cmp++;
            if (pulses - base != f / 4) begin
                n_fail++;
                $display("FAIL rate_s2 frame %0d: pulses %0d want %0d", f, pulses - base, f / 4);
            end
        end
        frame();
        ispeed = 3'd1;
        step(2);
        base = pulses;
        frame();
        n_cmp++;
        if (pulses != base) begin
            n_fail++;
            $display("FAIL speed_change_1st: pulses %0d want %0d", pulses, base);
        end
        frame();
        n_cmp++;
        if (pulses != base + 1) begin
            n_fail++;
            $display("FAIL speed_change_2nd: pulses %0d want %0d", pulses, base + 1);
        end
    endtask

    task automatic test_backpressure();
        int base_p;
        logic [23:0] base_c;
        ispeed = 3'd0;
        step(2);
        base_p = pulses;
        base_c = ostep_count;
        ibusy = 1'b1;
        for (int f = 0; f < 3; f++) frame();
        n_cmp++;
        if (pulses != base_p) begin
            n_fail++;
            $display("FAIL busy_hold: pulses %0d want %0d", pulses, base_p);
        end
        ibusy = 1'b0;
        step(1);
        n_cmp++;
        if (ostep !== 1'b0) begin
            n_fail++;
            $display("FAIL release_early: ostep %b want 0", ostep);
        end
        step(1);
        n_cmp++;
        if (ostep !== 1'b1) begin
            n_fail++;
            $display("FAIL release_pulse: ostep %b want 1", ostep);
        end
        step(5);
        n_cmp++;
        if (pulses != base_p + 1 || ostep_count !== base_c + 24'd1) begin
            n_fail++;
            $display("FAIL release_once: pulses %0d count %0d want %0d/%0d",
                     pulses - base_p, ostep_count, 1, base_c + 24'd1);
        end
    endtask

    task automatic test_pause_single();
        int base;
        start_edge();
        n_cmp++;
        if (orunning !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_enter: orunning %b want 0", orunning);
        end
        base = pulses;
        for (int f = 0; f < 4; f++) frame();
        n_cmp++;
        if (pulses != base) begin
            n_fail++;
            $display("FAIL pause_frames: pulses %0d want %0d", pulses, base);
        end
        istart = 1'b1;
        isingle = 1'b1;
        step(1);
        n_cmp++;
        if (orunning !== 1'b1) begin
            n_fail++;
            $display("FAIL start_wins_run: orunning %b want 1", orunning);
        end
        istart = 1'b0;
        isingle = 1'b0;
        step(3);
        n_cmp++;
        if (pulses != base) begin
            n_fail++;
            $display("FAIL start_wins_nostep: pulses %0d want %0d", pulses, base);
        end
        start_edge();
        isingle = 1'b1;
        step(1);
        n_cmp++;
        if (ostep !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: ostep %b want 0", ostep);
        end
        isingle = 1'b0;
        step(1);
        n_cmp++;
        if (ostep !== 1'b1 || orunning !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: ostep %b run %b want 1/0", ostep, orunning);
        end
        step(1);
        n_cmp++;
        if (ostep !== 1'b0) begin
            n_fail++;
            $display("FAIL single_width: ostep %b want 0", ostep);
        end
    endtask

    task automatic test_reset_abort();
        int base;
        start_edge();
        ibusy = 1'b1;
        frame();
        base = pulses;
        irstn = 1'b0;
        step(1);
        n_cmp++;
        if (ostep !== 1'b0 || orunning !== 1'b0 || ostep_count !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_abort: ostep %b run %b count %0d want 0/0/0",
                     ostep, orunning, ostep_count);
        end
        irstn = 1'b1;
        ibusy = 1'b0;
        step(6);
        n_cmp++;
        if (pulses != base) begin
            n_fail++;
            $display("FAIL reset_abort_pend: pulses %0d want %0d", pulses, base);
        end
    endtask

    task automatic test_saturate();
        rst_sat = 1'b1;
        step(2);
        for (int i = 1; i <= 8; i++) begin
            isingle = 1'b1;
            step(1);
            isingle = 1'b0;
            step(3);
            if (i >= 6) begin
                n_cmp++;
                if (s_count !== 3'(i > 7 ? 7 : i) || s_sat !== (i >= 7)) begin
                    n_fail++;
                    $display("FAIL saturate step %0d: count %0d sat %b want %0d/%b",
                             i, s_count, s_sat, (i > 7 ? 7 : i), (i >= 7));
                end
            end
        end
    endtask

`ifdef STEP_SEQ_LIMIT_EN
    task automatic test_limit();
        ispeed = 3'd0;
        step(2);
        rst_lim = 1'b1;
        step(2);
        start_edge();
        for (int f = 0; f < 6; f++) frame();
        n_cmp++;
        if (l_count !== 24'd4 || l_run !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_pause: count %0d run %b want 4/0", l_count, l_run);
        end
        start_edge();
        frame();
        n_cmp++;
        if (l_run !== 1'b0 || l_count !== 24'd4) begin
            n_fail++;
            $display("FAIL limit_lock: run %b count %0d want 0/4", l_run, l_count);
        end
    endtask
`endif

    task automatic test_back_to_back();
        n_cmp++;
        if (consec != 0) begin
            n_fail++;
            $display("FAIL back_to_back: consecutive-high cycles %0d want 0", consec);
        end
    endtask

    initial begin
        irstn = 1'b0;
        rst_sat = 1'b0;
        rst_lim = 1'b0;
        ivs = 1'b1;
        istart = 1'b0;
        isingle = 1'b0;
        ibusy = 1'b0;
        ispeed = 3'd0;
        test_reset();
        test_run_speed0();
        test_rate();
        test_backpressure();
        test_pause_single();
        test_reset_abort();
        test_saturate();
`ifdef STEP_SEQ_LIMIT_EN
        test_limit();
`endif
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
